voice_allocator: RTL and testbench

- Polyphonic note scheduler in front of the 8-voice synth bank.
- Accepts note-on/note-off events from the CPU-side register interface.
- Assigns each note-on to a free voice, or steals the oldest voice when all are busy.
- Drives the per-voice gate and note lines consumed by the oscillator/envelope voices.

---
 rtl/synth_pkg.sv | 22 ++
 rtl/voice_pick.sv | 76 +++++++
 rtl/voice_allocator.sv | 180 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice allocation path.
// Consumed by voice_allocator and voice_pick via import synth_pkg::*.
package synth_pkg;

  localparam int NOTE_W          = 7;
  localparam int DEFAULT_NOTE    = 60;
  localparam int NVOICES_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } alloc_state_e;

  typedef enum logic [1:0] {
    MATCH = 2'd0,
    FREE  = 2'd1,
    STEAL = 2'd2,
    NONE  = 2'd3
  } result_kind_e;

endpackage

// File: rtl/voice_pick.sv
// Running-best tracker fed one voice per SCAN cycle: first match, first free, oldest.
// Oldest tracking (and its age port) only exists when VOICE_ALLOC_STEAL_EN is defined.
module voice_pick
  import synth_pkg::*;
#(
  parameter int NVOICES = NVOICES_DEFAULT,
  parameter int IDXW    = 3
`ifdef VOICE_ALLOC_STEAL_EN
  , parameter int AGEBITS = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [IDXW-1:0]   idx_i,
  input  logic              gate_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [NOTE_W-1:0] ev_note_i,
  output logic              match_found_o,
  output logic [IDXW-1:0]   match_idx_o,
  output logic              free_found_o,
  output logic [IDXW-1:0]   free_idx_o
`ifdef VOICE_ALLOC_STEAL_EN
  , input  logic [AGEBITS-1:0] age_i
  , output logic [IDXW-1:0]    oldest_idx_o
`endif
);

  logic            match_found_q;
  logic [IDXW-1:0] match_idx_q;
  logic            free_found_q;
  logic [IDXW-1:0] free_idx_q;
`ifdef VOICE_ALLOC_STEAL_EN
  logic [IDXW-1:0]    oldest_idx_q;
  logic [AGEBITS-1:0] oldest_age_q;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
`endif
    end else if (valid_i) begin
      if (!match_found_q && gate_i && (note_i == ev_note_i)) begin
        match_found_q <= 1'b1;
        match_idx_q   <= idx_i;
      end
      if (!free_found_q && !gate_i) begin
        free_found_q <= 1'b1;
        free_idx_q   <= idx_i;
      end
`ifdef VOICE_ALLOC_STEAL_EN
      // Strictly greater keeps the lowest index on equal ages.
      if (age_i > oldest_age_q) begin
        oldest_idx_q <= idx_i;
        oldest_age_q <= age_i;
      end
`endif
    end
  end

  assign match_found_o = match_found_q;
  assign match_idx_o   = match_idx_q;
  assign free_found_o  = free_found_q;
  assign free_idx_o    = free_idx_q;
`ifdef VOICE_ALLOC_STEAL_EN
  assign oldest_idx_o  = oldest_idx_q;
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: IDLE -> SCAN (one voice per cycle) -> APPLY.
// Voice stealing of the oldest voice is built only with VOICE_ALLOC_STEAL_EN.
// Handshake: an event transfers on a clk edge where event_valid && event_ready;
// event_ready is high only in IDLE, and the event fields are latched at that edge.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NVOICES      = NVOICES_DEFAULT,
  parameter int AGEBITS      = 8,
  parameter int DEFAULT_NOTE = synth_pkg::DEFAULT_NOTE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      event_valid,
  output logic                      event_ready,
  input  logic                      event_on,
  input  logic [NOTE_W-1:0]         event_note,
  input  logic                      all_off,
  output logic [NVOICES-1:0]        voice_gate,
  output logic [NVOICES*NOTE_W-1:0] voice_note,
  output logic                      stolen,
  output logic                      dropped,
  output logic [1:0]                dbg_state
);

  localparam int IDXW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NVOICES - 1);

  alloc_state_e      state_q;
  logic [IDXW-1:0]   idx_q;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [NVOICES-1:0] gate_q;
  logic [NOTE_W-1:0] note_q [NVOICES];
  logic              stolen_q;
  logic              dropped_q;

  logic              accept;
  logic              match_found;
  logic              free_found;
  logic [IDXW-1:0]   match_idx;
  logic [IDXW-1:0]   free_idx;
  result_kind_e      kind;
  logic [IDXW-1:0]   tgt;
`ifdef VOICE_ALLOC_STEAL_EN
  logic [AGEBITS-1:0] age_q [NVOICES];
  logic [IDXW-1:0]    oldest_idx;
`endif

  assign event_ready = (state_q == IDLE);
  // all_off wins over a same-edge acceptance.
  assign accept      = event_valid && event_ready && !all_off;
  assign voice_gate  = gate_q;
  assign stolen      = stolen_q;
  assign dropped     = dropped_q;
  assign dbg_state   = state_q;

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NVOICES; i++) begin
      voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
    end
  end

  voice_pick #(
    .NVOICES (NVOICES),
    .IDXW    (IDXW)
`ifdef VOICE_ALLOC_STEAL_EN
    , .AGEBITS (AGEBITS)
`endif
  ) u_pick (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (accept),
    .valid_i       (state_q == SCAN),
    .idx_i         (idx_q),
    .gate_i        (gate_q[idx_q]),
    .note_i        (note_q[idx_q]),
    .ev_note_i     (ev_note_q),
    .match_found_o (match_found),
    .match_idx_o   (match_idx),
    .free_found_o  (free_found),
    .free_idx_o    (free_idx)
`ifdef VOICE_ALLOC_STEAL_EN
    , .age_i        (age_q[idx_q])
    , .oldest_idx_o (oldest_idx)
`endif
  );

  always_comb begin
    kind = NONE;
    tgt  = '0;
    if (match_found) begin
      kind = MATCH;
      tgt  = match_idx;
    end else if (free_found) begin
      kind = FREE;
      tgt  = free_idx;
    end else begin
`ifdef VOICE_ALLOC_STEAL_EN
      kind = STEAL;
      tgt  = oldest_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      gate_q    <= '0;
      stolen_q  <= 1'b0;
      dropped_q <= 1'b0;
      for (int i = 0; i < NVOICES; i++) begin
        note_q[i] <= NOTE_W'(DEFAULT_NOTE);
`ifdef VOICE_ALLOC_STEAL_EN
        age_q[i]  <= '0;
`endif
      end
    end else begin
      stolen_q  <= 1'b0;
      dropped_q <= 1'b0;
      if (all_off) begin
        gate_q  <= '0;
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              ev_on_q   <= event_on;
              ev_note_q <= event_note;
              idx_q     <= '0;
              state_q   <= SCAN;
            end
          end
          SCAN: begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_q <= APPLY;
          end
          APPLY: begin
            state_q <= IDLE;
            if (ev_on_q) begin
              case (kind)
                MATCH: ;
                FREE: begin
                  note_q[tgt] <= ev_note_q;
                  gate_q[tgt] <= 1'b1;
                end
                STEAL: begin
                  note_q[tgt] <= ev_note_q;
                  stolen_q    <= 1'b1;
                end
                default: dropped_q <= 1'b1;
              endcase
`ifdef VOICE_ALLOC_STEAL_EN
              // Target restarts at age 0; others age only on a fresh assignment.
              if (kind != NONE) begin
                for (int i = 0; i < NVOICES; i++) begin
                  if (IDXW'(i) == tgt) age_q[i] <= '0;
                  else if (kind != MATCH && age_q[i] != '1) age_q[i] <= age_q[i] + 1'b1;
                end
              end
`endif
            end else begin
              // Release keeps the note so the envelope tail plays the right pitch.
              for (int i = 0; i < NVOICES; i++) begin
                if (gate_q[i] && (note_q[i] == ev_note_q)) gate_q[i] <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator; full-bank expectations follow VOICE_ALLOC_STEAL_EN.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        event_valid = 1'b0;
  logic        event_on = 1'b0;
  logic [6:0]  event_note = 7'd0;
  logic        all_off = 1'b0;
  logic        event_ready;
  logic [7:0]  voice_gate;
  logic [55:0] voice_note;
  logic        stolen;
  logic        dropped;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad = 0;
  int          lat;
  logic        st, dr, seen;
  logic [55:0] exp_notes;

  voice_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_on    (event_on),
    .event_note  (event_note),
    .all_off     (all_off),
    .voice_gate  (voice_gate),
    .voice_note  (voice_note),
    .stolen      (stolen),
    .dropped     (dropped),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] vnote(input int i);
    return voice_note[i*7 +: 7];
  endfunction

  function automatic logic holds_note(input logic [6:0] n);
    logic hit = 1'b0;
    for (int i = 0; i < 8; i++) if (vnote(i) == n) hit = 1'b1;
    return hit;
  endfunction

  // Present one event, scramble the inputs after acceptance, wait for ready.
  task automatic send_event(input logic on, input logic [6:0] note,
                            output int l, output logic s, output logic d);
    event_valid = 1'b1;
    event_on    = on;
    event_note  = note;
    tick();
    event_valid = 1'b0;
    event_on    = ~on;
    event_note  = 7'($urandom_range(0, 127));
    l = 0;
    while (!event_ready && l < 20) begin
      tick();
      l++;
    end
    s = stolen;
    d = dropped;
  endtask

  task automatic do_event(input string tag, input logic on, input logic [6:0] note,
                          input logic exp_st, input logic exp_dr);
    send_event(on, note, lat, st, dr);
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_stolen"}, 64'(st), 64'(exp_st));
    check({tag, "_dropped"}, 64'(dr), 64'(exp_dr));
    tick();
    check({tag, "_pulse_clear"}, {62'd0, stolen, dropped}, 64'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_gate", 64'(voice_gate), 64'h00);
    check("rst_notes", 64'(voice_note), 64'({8{7'd60}}));
    check("rst_ready", 64'(event_ready), 64'd1);
    check("rst_pulses", {62'd0, stolen, dropped}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // Basic allocation
    do_event("on60", 1'b1, 7'd60, 1'b0, 1'b0);
    check("on60_gate", 64'(voice_gate), 64'h01);
    check("on60_note0", 64'(vnote(0)), 64'd60);
    do_event("on64", 1'b1, 7'd64, 1'b0, 1'b0);
    check("on64_gate", 64'(voice_gate), 64'h03);
    check("on64_note1", 64'(vnote(1)), 64'd64);

    // Note-off release keeps pitch; unmatched note-off is a no-op
    do_event("off60", 1'b0, 7'd60, 1'b0, 1'b0);
    check("off60_gate", 64'(voice_gate), 64'h02);
    check("off60_note0", 64'(vnote(0)), 64'd60);
    do_event("off61", 1'b0, 7'd61, 1'b0, 1'b0);
    check("off61_gate", 64'(voice_gate), 64'h02);

    // Retrigger must not claim the free voice 0
    do_event("retrig64", 1'b1, 7'd64, 1'b0, 1'b0);
    check("retrig_gate", 64'(voice_gate), 64'h02);
    check("retrig_note0", 64'(vnote(0)), 64'd60);
    check("retrig_note1", 64'(vnote(1)), 64'd64);

    // Single-cycle panic in IDLE: gates clear, notes kept
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    check("panic_idle_gate", 64'(voice_gate), 64'h00);
    check("panic_idle_note1", 64'(vnote(1)), 64'd64);
    check("panic_idle_ready", 64'(event_ready), 64'd1);

    // Fill the bank
    for (int n = 40; n < 48; n++) do_event($sformatf("fill%0d", n), 1'b1, 7'(n), 1'b0, 1'b0);
    check("full_gate", 64'(voice_gate), 64'hff);
    for (int i = 0; i < 8; i++) exp_notes[i*7 +: 7] = 7'(40 + i);
    check("full_notes", 64'(voice_note), 64'(exp_notes));

`ifdef VOICE_ALLOC_STEAL_EN
    // Voice 0 is oldest (age 7), then voice 1 after the first steal
    do_event("steal50", 1'b1, 7'd50, 1'b1, 1'b0);
    exp_notes[6:0] = 7'd50;
    check("steal50_notes", 64'(voice_note), 64'(exp_notes));
    check("steal50_gate", 64'(voice_gate), 64'hff);
    do_event("steal51", 1'b1, 7'd51, 1'b1, 1'b0);
    exp_notes[13:7] = 7'd51;
    check("steal51_notes", 64'(voice_note), 64'(exp_notes));
`else
    do_event("drop50", 1'b1, 7'd50, 1'b0, 1'b1);
    check("drop50_notes", 64'(voice_note), 64'(exp_notes));
    check("drop50_gate", 64'(voice_gate), 64'hff);
`endif

    // Panic mid-scan: accept 70, all_off on the third edge after acceptance
    event_valid = 1'b1;
    event_on    = 1'b1;
    event_note  = 7'd70;
    tick();
    event_valid = 1'b0;
    check("scan_entered", 64'(event_ready), 64'd0);
    tick();
    tick();
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    check("panic_scan_gate", 64'(voice_gate), 64'h00);
    check("panic_scan_ready", 64'(event_ready), 64'd1);
    check("panic_scan_pulses", {62'd0, stolen, dropped}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen = seen | stolen | dropped;
    end
    check("panic_scan_no_late_pulse", 64'(seen), 64'd0);
    check("panic_scan_no70", 64'(holds_note(7'd70)), 64'd0);
    check("panic_scan_notes_kept", 64'(voice_note), 64'(exp_notes));
    check("panic_scan_gate_later", 64'(voice_gate), 64'h00);

    // all_off beats acceptance on the same edge
    event_valid = 1'b1;
    event_note  = 7'd70;
    all_off     = 1'b1;
    tick();
    check("prio_state", 64'(dbg_state), 64'd0);
    check("prio_ready", 64'(event_ready), 64'd1);
    event_valid = 1'b0;
    all_off     = 1'b0;
    repeat (12) tick();
    check("prio_no70", 64'(holds_note(7'd70)), 64'd0);
    check("prio_gate", 64'(voice_gate), 64'h00);

    // rst mid-scan returns everything to reset values
    event_valid = 1'b1;
    event_on    = 1'b1;
    event_note  = 7'd70;
    tick();
    event_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_gate", 64'(voice_gate), 64'h00);
    check("rst_mid_notes", 64'(voice_note), 64'({8{7'd60}}));
    check("rst_mid_ready", 64'(event_ready), 64'd1);
    check("rst_mid_pulses", {62'd0, stolen, dropped}, 64'd0);
    repeat (12) tick();
    check("rst_mid_gate_later", 64'(voice_gate), 64'h00);
    check("rst_mid_notes_later", 64'(voice_note), 64'({8{7'd60}}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
